query_responder: RTL and testbench

QUERY_RESPONDER -- requirements
Module: query_responder

---
 rtl/query_responder.sv | 207 ++++++++++++++++++++
 tb/tb_query_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/query_responder.sv
// rtl/query_responder.sv - pixel query responder; optional bounds check via QUERY_BOUNDS_CHECK_EN
module query_responder (
    input  logic        clk_25,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  query_x,
    input  logic [9:0]  query_y,
    output logic        ready,
    output logic [9:0]  return_x,
    output logic [9:0]  return_y,
    output logic [4:0]  r,
    output logic [5:0]  g,
    output logic [4:0]  b,
    output logic        mem_rd,
    output logic [18:0] mem_addr,
    input  logic        mem_busy,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdvalid,
    output logic        debug
);

    typedef enum logic {ISSUE_IDLE, ISSUE_REQ} issue_state_t;

    // Query queue: one slot per outstanding query, retired in arrival order.
    logic [9:0]  q_x   [8];
    logic [9:0]  q_y   [8];
    logic [15:0] q_pix [8];
    logic [7:0]  q_done;
`ifdef QUERY_BOUNDS_CHECK_EN
    logic [7:0]  q_oor;
`endif
    logic [2:0]  head, tail;
    logic [3:0]  count;

    // Slots waiting for a read, in queue order.
    logic [2:0]  iss_idx [8];
    logic [2:0]  iss_wr, iss_rd;
    logic [3:0]  iss_cnt;

    // Slots whose read was accepted; memory returns data in this order.
    logic [2:0]  fl_idx [8];
    logic [2:0]  fl_wr, fl_rd;
    logic [3:0]  fl_cnt;

    issue_state_t state;
    logic [2:0]   req_idx;

    logic        retire, enq, drop, in_range, need_issue;
    logic        can_issue, accept, from_fifo, from_start, issue, push_iss;
    logic        fl_pop, rd_orphan;
    logic [2:0]  cand_idx;
    logic [18:0] cand_addr;
    logic [15:0] head_pix;

    // y*640 + x as two shifts and adds, wrapping at 19 bits.
    function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
        return {y, 9'b0} + {2'b0, y, 7'b0} + {9'b0, x};
    endfunction

`ifdef QUERY_BOUNDS_CHECK_EN
    assign in_range = (query_x < 10'd640) && (query_y < 10'd480);
    assign head_pix = q_oor[head] ? 16'h0000 : q_pix[head];
`else
    assign in_range = 1'b1;
    assign head_pix = q_pix[head];
`endif

    assign retire     = (count != 4'd0) && q_done[head];
    assign enq        = start && ((count != 4'd8) || retire);
    assign drop       = start && !enq;
    assign need_issue = enq && in_range;

    // A new request may go out from idle, or back-to-back once the current one is taken.
    assign can_issue  = (state == ISSUE_IDLE) || !mem_busy;
    assign accept     = (state == ISSUE_REQ) && !mem_busy;
    assign from_fifo  = can_issue && (iss_cnt != 4'd0);
    // With nothing queued for issue, a fresh query goes straight to memory.
    assign from_start = can_issue && (iss_cnt == 4'd0) && need_issue;
    assign issue      = from_fifo || from_start;
    assign push_iss   = need_issue && !from_start;

    assign fl_pop     = mem_rdvalid && (fl_cnt != 4'd0);
    assign rd_orphan  = mem_rdvalid && (fl_cnt == 4'd0);

    // Pick the next read candidate: oldest pending slot, else the arriving query.
    always_comb begin
        cand_idx  = tail;
        cand_addr = pix_addr(query_x, query_y);
        if (from_fifo) begin
            cand_idx  = iss_idx[iss_rd];
            cand_addr = pix_addr(q_x[iss_idx[iss_rd]], q_y[iss_idx[iss_rd]]);
        end
    end

    // Queue storage, data return, in-order retire and the sticky error flag.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            head     <= 3'd0;
            tail     <= 3'd0;
            count    <= 4'd0;
            q_done   <= 8'd0;
`ifdef QUERY_BOUNDS_CHECK_EN
            q_oor    <= 8'd0;
`endif
            for (int i = 0; i < 8; i++) begin
                q_x[i]   <= 10'd0;
                q_y[i]   <= 10'd0;
                q_pix[i] <= 16'd0;
            end
            ready    <= 1'b0;
            return_x <= 10'd0;
            return_y <= 10'd0;
            r        <= 5'd0;
            g        <= 6'd0;
            b        <= 5'd0;
            debug    <= 1'b0;
        end else begin
            ready <= retire;
            if (retire) begin
                return_x  <= q_x[head];
                return_y  <= q_y[head];
                {r, g, b} <= head_pix;
                head      <= head + 3'd1;
            end
            if (fl_pop) begin
                q_pix[fl_idx[fl_rd]]  <= mem_rdata;
                q_done[fl_idx[fl_rd]] <= 1'b1;
            end
            if (enq) begin
                q_x[tail]    <= query_x;
                q_y[tail]    <= query_y;
                q_pix[tail]  <= 16'd0;
                q_done[tail] <= !in_range;
`ifdef QUERY_BOUNDS_CHECK_EN
                q_oor[tail]  <= !in_range;
`endif
                tail         <= tail + 3'd1;
            end
            count <= count + {3'b0, enq} - {3'b0, retire};
            if (drop || rd_orphan) begin
                debug <= 1'b1;
            end
        end
    end

    // Issue FSM with its pending and in-flight index FIFOs; memory outputs are registered.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            state    <= ISSUE_IDLE;
            mem_rd   <= 1'b0;
            mem_addr <= 19'd0;
            req_idx  <= 3'd0;
            iss_wr   <= 3'd0;
            iss_rd   <= 3'd0;
            iss_cnt  <= 4'd0;
            fl_wr    <= 3'd0;
            fl_rd    <= 3'd0;
            fl_cnt   <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                iss_idx[i] <= 3'd0;
                fl_idx[i]  <= 3'd0;
            end
        end else begin
            if (push_iss) begin
                iss_idx[iss_wr] <= tail;
                iss_wr          <= iss_wr + 3'd1;
            end
            if (from_fifo) begin
                iss_rd <= iss_rd + 3'd1;
            end
            iss_cnt <= iss_cnt + {3'b0, push_iss} - {3'b0, from_fifo};

            if (accept) begin
                fl_idx[fl_wr] <= req_idx;
                fl_wr         <= fl_wr + 3'd1;
            end
            if (fl_pop) begin
                fl_rd <= fl_rd + 3'd1;
            end
            fl_cnt <= fl_cnt + {3'b0, accept} - {3'b0, fl_pop};

            case (state)
                ISSUE_IDLE: begin
                    if (issue) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= cand_addr;
                        req_idx  <= cand_idx;
                        state    <= ISSUE_REQ;
                    end
                end
                ISSUE_REQ: begin
                    if (!mem_busy) begin
                        if (issue) begin
                            mem_addr <= cand_addr;
                            req_idx  <= cand_idx;
                        end else begin
                            mem_rd <= 1'b0;
                            state  <= ISSUE_IDLE;
                        end
                    end
                end
                default: state <= ISSUE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_query_responder.sv
// tb/tb_query_responder.sv - scoreboard bench for query_responder
module tb_query_responder;

    logic        clk_25 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  query_x = 10'd0;
    logic [9:0]  query_y = 10'd0;
    logic        ready;
    logic [9:0]  return_x, return_y;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
    logic        mem_rd;
    logic [18:0] mem_addr;
    logic        mem_busy = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_rdvalid = 1'b0;
    logic        debug;

    query_responder dut (
        .clk_25(clk_25), .rst(rst), .start(start), .query_x(query_x), .query_y(query_y),
        .ready(ready), .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_busy(mem_busy), .mem_rdata(mem_rdata),
        .mem_rdvalid(mem_rdvalid), .debug(debug)
    );

    always #20 clk_25 = ~clk_25;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] pix;
    } exp_t;

    typedef struct {
        logic [18:0] a;
        int          due;
    } rd_t;

    exp_t exp_q[$];
    rd_t  mq[$];
    int   n_checks = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   mem_lat = 3;
    int   acc_cnt = 0;
    int   rdy_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_data(input logic [18:0] a);
        return a[15:0] ^ {13'b0, a[18:16]} ^ 16'hC35A;
    endfunction

    function automatic logic [18:0] ref_addr(input int x, input int y);
        int s;
        s = (y * 640 + x) % 524288;
        return s[18:0];
    endfunction

    function automatic logic [15:0] ref_pix(input int x, input int y);
`ifdef QUERY_BOUNDS_CHECK_EN
        if (x >= 640 || y >= 480) return 16'h0000;
`endif
        return mem_data(ref_addr(x, y));
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_25);
            #1;
        end
    endtask

    task automatic send(input int x, input int y, input bit expect_it);
        start   = 1'b1;
        query_x = x[9:0];
        query_y = y[9:0];
        if (expect_it) exp_q.push_back('{x: x[9:0], y: y[9:0], pix: ref_pix(x, y)});
        step(1);
        start = 1'b0;
    endtask

    task automatic drain(input string nm, input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step(1);
            n++;
        end
        chk(nm, exp_q.size(), 0);
        step(2);
    endtask

    // Memory model: accepted read in cycle c returns data in cycle c+mem_lat-1.
    always @(negedge clk_25) begin
        if (mem_rd && !mem_busy) begin
            mq.push_back('{a: mem_addr, due: cyc + mem_lat - 1});
            acc_cnt++;
        end
    end

    always @(posedge clk_25) begin
        #1;
        cyc++;
        if (mq.size() != 0 && mq[0].due == cyc) begin
            mem_rdvalid = 1'b1;
            mem_rdata   = mem_data(mq[0].a);
            void'(mq.pop_front());
        end else begin
            mem_rdvalid = 1'b0;
        end
    end

    // Result monitor: every ready pulse pops the scoreboard; results hold between pulses.
    logic [35:0] held;
    bit          hold_v = 0;
    always @(negedge clk_25) begin
        exp_t e;
        if (rst) begin
            hold_v = 0;
        end else begin
            if (ready) begin
                rdy_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ready", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("return_x", return_x, e.x);
                    chk("return_y", return_y, e.y);
                    chk("pixel", {r, g, b}, e.pix);
                end
            end else if (hold_v) begin
                chk("result_hold", {return_x, return_y, r, g, b}, held);
            end
            held   = {return_x, return_y, r, g, b};
            hold_v = 1;
        end
    end

    // Stalled request must keep mem_rd and mem_addr unchanged.
    bit          prev_stall = 0;
    logic [18:0] prev_addr;
    always @(negedge clk_25) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_rd", mem_rd, 1);
                chk("stall_addr", mem_addr, prev_addr);
            end
            prev_stall = mem_rd && mem_busy;
            prev_addr  = mem_addr;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int a0;
        int r0;

        step(2);
        rst = 1'b0;
        @(negedge clk_25);
        chk("rst_ready", ready, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_return", {return_x, return_y, r, g, b}, 0);
        chk("rst_debug", debug, 0);
        step(1);

        // Single query, latency and address.
        send(12, 3, 1);
        rc = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_25);
            if (k == 1) begin
                chk("t1_mem_rd", mem_rd, 1);
                chk("t1_mem_addr", mem_addr, 1932);
            end
            if (ready && rc == 0) rc = k;
        end
        chk("t1_latency", rc, 5);
        step(1);
        drain("t1_drain", 20);

        // Burst of five with a four-cycle stall.
        send(5, 7, 1);
        mem_busy = 1'b1;
        send(100, 200, 1);
        send(639, 479, 1);
        send(0, 0, 1);
        send(320, 240, 1);
        mem_busy = 1'b0;
        drain("t2_drain", 60);
        chk("t2_debug", debug, 0);

        // Ten queries under a stall: the last two are dropped.
        mem_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(10 * i + 1, 2 * i + 3, i < 8);
        end
        chk("t3_debug", debug, 1);
        step(3);
        mem_busy = 1'b0;
        drain("t3_drain", 80);

`ifdef QUERY_BOUNDS_CHECK_EN
        // Out-of-range query returns zero without a read, ahead of the next one.
        a0 = acc_cnt;
        send(700, 5, 1);
        send(1, 1, 1);
        @(negedge clk_25);
        chk("oor_next_rd", mem_rd, 1);
        chk("oor_next_addr", mem_addr, 641);
        step(1);
        drain("oor_drain", 20);
        chk("oor_reads", acc_cnt - a0, 1);
`else
        // Address wraps at 19 bits without bounds checking.
        a0 = acc_cnt;
        send(1023, 1023, 1);
        @(negedge clk_25);
        chk("wrap_rd", mem_rd, 1);
        chk("wrap_addr", mem_addr, 131455);
        step(1);
        send(700, 5, 1);
        drain("wrap_drain", 20);
        chk("wrap_reads", acc_cnt - a0, 2);
`endif

        // Reset with three reads in flight; late data is an error, not a result.
        mem_lat = 10;
        send(2, 2, 1);
        send(3, 3, 1);
        send(4, 4, 1);
        step(1);
        rst = 1'b1;
        exp_q.delete();
        r0 = rdy_cnt;
        step(1);
        rst = 1'b0;
        @(negedge clk_25);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_mem_rd", mem_rd, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_return", {return_x, return_y, r, g, b}, 0);
        chk("mid_rst_debug", debug, 0);
        step(12);
        chk("late_debug", debug, 1);
        chk("late_no_ready", rdy_cnt - r0, 0);
        chk("late_returns_seen", mq.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
